reg_bank_sb: RTL and testbench
==============================

REG_BANK_SB -- requirements
Module: reg_bank_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width of every register.
REQ-002 SHALL have parameter GPR_NUM, default 8, number of general registers (power of two, 4..32).
REQ-003 SHALL have parameter ZERO_R0, default 0; when 1, GPR 0 reads as zero and ignores writes.
REQ-004 SHALL have derived localparam SEL_W = clog2(GPR_NUM+4), width of the unified register selector.
REQ-005 SHALL map selector values as: 0..GPR_NUM-1 = GPRs, GPR_NUM = T, GPR_NUM+1 = SP, GPR_NUM+2 = IH, GPR_NUM+3 = RA; higher values are invalid.
REQ-006 SHALL have ports, clock and reset first:
 clk_50MHz  in  1  sole clock, rising edge.
 rst  in  1  asynchronous, active-high reset.
 a_sel  in  SEL_W  read port A selector.
 b_sel  in  SEL_W  read port B selector.
 a_data  out  DATA_W  read port A data.
 b_data  out  DATA_W  read port B data.
 iss_valid  in  1  an instruction is issuing with a destination.
 iss_sel  in  SEL_W  destination of the issuing instruction.
 iss_use_a / iss_use_b  in  1 each  issuing instruction reads port A / B.
 wb_valid  in  1  write-back strobe.
 wb_sel  in  SEL_W  write-back destination.
 wb_data  in  DATA_W  write-back data.
 flush  in  1  clear all pending-write marks.
 stall  out  1  issue must be held this cycle.
 busy  out  GPR_NUM+4  pending-write bit per register.

Function
REQ-007 SHALL write wb_data to the register at wb_sel on the rising edge when wb_valid=1 and wb_sel is valid.
REQ-008 SHALL drive a_data/b_data combinationally; when wb_valid=1 and wb_sel equals the read selector, wb_data SHALL be forwarded (same-cycle bypass).
REQ-009 SHALL return zero for invalid selectors and, when ZERO_R0=1, for selector 0 (bypass suppressed).
REQ-010 SHALL set busy[iss_sel] on the rising edge when iss_valid=1, stall=0, flush=0 and iss_sel valid.
REQ-011 SHALL clear busy[wb_sel] on the rising edge when wb_valid=1, unless the same edge sets it via REQ-010 (set wins).
REQ-012 SHALL assert stall when iss_valid=1 and any of: iss_use_a and busy[a_sel] and not bypassed; iss_use_b and busy[b_sel] and not bypassed; busy[iss_sel] and not cleared by the current write-back (WAW).
REQ-013 SHALL never set busy for selector 0 when ZERO_R0=1, nor for invalid selectors.
REQ-014 SHALL clear all busy bits on the rising edge when flush=1; flush SHALL NOT block the write of REQ-007; a same-cycle issue SHALL be discarded.
REQ-015 stall SHALL be purely combinational (zero latency); a_data/b_data SHALL reflect a write one edge after it is taken when not bypassed.

Reset
REQ-016 SHALL, while rst=1, clear every register (GPRs, T, SP, IH, RA) and every busy bit to zero asynchronously.
REQ-017 SHALL hold stall=0 during reset; a_data/b_data SHALL read zero unless bypassed.
REQ-018 SHALL ignore wb_valid, iss_valid and flush during reset; the first write SHALL take effect on the first rising edge after rst falls.

Structure
REQ-019 SHALL place the special-register offsets (T=0, SP=1, IH=2, RA=3 relative to GPR_NUM) and the DATA_W/GPR_NUM defaults in the shared define package.
REQ-020 SHALL implement the busy vector and stall logic as one sub-module, reg_scoreboard; storage and bypass stay in the top.

Verification
REQ-021 Reset: rst=1 with wb_valid=1 to GPR3 -> all reads 0, busy=0, stall=0.
REQ-022 Bypass: wb GPR2=0x1234 with a_sel=2 same cycle -> a_data=0x1234 before the edge; still 0x1234 after it.
REQ-023 RAW stall: issue dest GPR5; next cycle issue using a_sel=5 -> stall=1; wb GPR5=0x00FF -> stall=0 that cycle, a_data=0x00FF.
REQ-024 Set-wins: issue dest SP while wb to SP=0x8000 same edge -> SP=0x8000, busy[SP]=1.
REQ-025 Flush: busy on GPR1, GPR7, RA; flush=1 with wb GPR1=0x0042 -> busy=0, GPR1=0x0042.
REQ-026 ZERO_R0=1: wb GPR0=0xFFFF -> a_sel=0 reads 0 before and after the edge; issue to GPR0 leaves busy[0]=0.

Source files
------------

// File: rtl/reg_bank_sb_pkg.sv
// Shared definitions for the reg_bank_sb register bank:
// default sizes, special-register offsets and selector helpers.
package reg_bank_sb_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int GPR_NUM_DEF = 8;

  // Special registers sit directly above the GPRs.
  typedef enum int {
    OFF_T  = 0,
    OFF_SP = 1,
    OFF_IH = 2,
    OFF_RA = 3
  } spec_off_e;

  localparam int N_SPEC = OFF_RA + 1;

  function automatic int sel_w(input int gpr_num);
    return $clog2(gpr_num + N_SPEC);
  endfunction

  function automatic logic sel_valid(
    input int unsigned s,
    input int unsigned nreg
  );
    return s < nreg;
  endfunction

endpackage

// File: rtl/reg_bank_sb_if.sv
// Read, issue and write-back bus of reg_bank_sb.
// master = pipeline side, slave = register bank.
interface reg_bank_sb_if
  import reg_bank_sb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GPR_NUM = GPR_NUM_DEF
);
  localparam int SEL_W = sel_w(GPR_NUM);
  localparam int NREG  = GPR_NUM + N_SPEC;

  logic [SEL_W-1:0]  a_sel;
  logic [SEL_W-1:0]  b_sel;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              iss_valid;
  logic [SEL_W-1:0]  iss_sel;
  logic              iss_use_a;
  logic              iss_use_b;
  logic              wb_valid;
  logic [SEL_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              stall;
  logic [NREG-1:0]   busy;

  modport master (
    output a_sel, b_sel,
    output iss_valid, iss_sel,
    output iss_use_a, iss_use_b,
    output wb_valid, wb_sel, wb_data,
    output flush,
    input  a_data, b_data,
    input  stall, busy
  );

  modport slave (
    input  a_sel, b_sel,
    input  iss_valid, iss_sel,
    input  iss_use_a, iss_use_b,
    input  wb_valid, wb_sel, wb_data,
    input  flush,
    output a_data, b_data,
    output stall, busy
  );

endinterface

// File: rtl/reg_bank_sb_scoreboard.sv
// reg_scoreboard: pending-write bit per register plus
// RAW/WAW stall detection with write-back bypass awareness.
module reg_scoreboard
  import reg_bank_sb_pkg::*;
#(
  parameter int GPR_NUM = GPR_NUM_DEF,
  parameter int ZERO_R0 = 0,
  localparam int SEL_W  = sel_w(GPR_NUM),
  localparam int NREG   = GPR_NUM + N_SPEC
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [SEL_W-1:0] iss_sel,
  input  logic             iss_use_a,
  input  logic             iss_use_b,
  input  logic [SEL_W-1:0] a_sel,
  input  logic [SEL_W-1:0] b_sel,
  input  logic             wb_valid,
  input  logic [SEL_W-1:0] wb_sel,
  input  logic             flush,
  output logic             stall,
  output logic [NREG-1:0]  busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            hit_a;
  logic            hit_b;
  logic            waw;
  logic            set_en;
  logic            clr_en;

  function automatic logic ok(input logic [SEL_W-1:0] s);
    return sel_valid(32'(s), NREG);
  endfunction

  function automatic logic is_busy(
    input logic [NREG-1:0]  v,
    input logic [SEL_W-1:0] s
  );
    return ok(s) && v[s];
  endfunction

  // A matching write-back this cycle resolves the hazard.
  always_comb begin
    hit_a = iss_use_a && is_busy(busy_q, a_sel) &&
            !(wb_valid && wb_sel == a_sel);
    hit_b = iss_use_b && is_busy(busy_q, b_sel) &&
            !(wb_valid && wb_sel == b_sel);
    waw   = is_busy(busy_q, iss_sel) &&
            !(wb_valid && wb_sel == iss_sel);
    stall = !rst && iss_valid && (hit_a || hit_b || waw);
  end

  always_comb begin
    set_en = iss_valid && !stall && !flush && ok(iss_sel) &&
             !((ZERO_R0 != 0) && iss_sel == '0);
    clr_en = wb_valid && ok(wb_sel);
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[wb_sel] = 1'b0;
      if (set_en) busy_d[iss_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: GPRs + T/SP/IH/RA with two bypassed read ports,
// one write-back port and a scoreboard. Ports: clk_50MHz, rst, bus.
module reg_bank_sb
  import reg_bank_sb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GPR_NUM = GPR_NUM_DEF,
  parameter int ZERO_R0 = 0,
  localparam int SEL_W  = sel_w(GPR_NUM),
  localparam int NREG   = GPR_NUM + N_SPEC
) (
  input logic         clk_50MHz,
  input logic         rst,
  reg_bank_sb_if.slave bus
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en;
  logic              byp_a;
  logic              byp_b;

  function automatic logic ok(input logic [SEL_W-1:0] s);
    return sel_valid(32'(s), NREG);
  endfunction

  function automatic logic is_r0(input logic [SEL_W-1:0] s);
    return (ZERO_R0 != 0) && s == '0;
  endfunction

  assign wr_en = bus.wb_valid && ok(bus.wb_sel) && !is_r0(bus.wb_sel);

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.wb_sel] <= bus.wb_data;
    end
  end

  assign byp_a = bus.wb_valid && bus.wb_sel == bus.a_sel;
  assign byp_b = bus.wb_valid && bus.wb_sel == bus.b_sel;

  always_comb begin
    bus.a_data = '0;
    if (ok(bus.a_sel) && !is_r0(bus.a_sel))
      bus.a_data = byp_a ? bus.wb_data : regs[bus.a_sel];
  end

  always_comb begin
    bus.b_data = '0;
    if (ok(bus.b_sel) && !is_r0(bus.b_sel))
      bus.b_data = byp_b ? bus.wb_data : regs[bus.b_sel];
  end

  reg_scoreboard #(
    .GPR_NUM (GPR_NUM),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .iss_valid (bus.iss_valid),
    .iss_sel   (bus.iss_sel),
    .iss_use_a (bus.iss_use_a),
    .iss_use_b (bus.iss_use_b),
    .a_sel     (bus.a_sel),
    .b_sel     (bus.b_sel),
    .wb_valid  (bus.wb_valid),
    .wb_sel    (bus.wb_sel),
    .flush     (bus.flush),
    .stall     (bus.stall),
    .busy      (bus.busy)
  );

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench for reg_bank_sb: cycle table on a ZERO_R0=0 bank,
// hand sequences for async reset and a ZERO_R0=1 bank.
module tb_reg_bank_sb;

  logic clk;
  logic rst;

  reg_bank_sb_if #(.DATA_W(16), .GPR_NUM(8)) bus0 ();
  reg_bank_sb_if #(.DATA_W(16), .GPR_NUM(8)) bus1 ();

  reg_bank_sb #(.DATA_W(16), .GPR_NUM(8), .ZERO_R0(0)) dut0 (
    .clk_50MHz (clk),
    .rst       (rst),
    .bus       (bus0)
  );

  reg_bank_sb #(.DATA_W(16), .GPR_NUM(8), .ZERO_R0(1)) dut1 (
    .clk_50MHz (clk),
    .rst       (rst),
    .bus       (bus1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  as;
    logic [3:0]  bs;
    logic        iv;
    logic [3:0]  is;
    logic        ua;
    logic        ub;
    logic        wv;
    logic [3:0]  ws;
    logic [15:0] wd;
    logic        fl;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        es;
    logic [11:0] ebusy;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(
    logic r, logic [3:0] as, logic [3:0] bs,
    logic iv, logic [3:0] is, logic ua, logic ub,
    logic wv, logic [3:0] ws, logic [15:0] wd, logic fl,
    logic [15:0] ea, logic [15:0] eb, logic es,
    logic [11:0] ebusy
  );
    vec_t v;
    v.r = r; v.as = as; v.bs = bs;
    v.iv = iv; v.is = is; v.ua = ua; v.ub = ub;
    v.wv = wv; v.ws = ws; v.wd = wd; v.fl = fl;
    v.ea = ea; v.eb = eb; v.es = es; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle0();
    bus0.a_sel = '0; bus0.b_sel = '0;
    bus0.iss_valid = 0; bus0.iss_sel = '0;
    bus0.iss_use_a = 0; bus0.iss_use_b = 0;
    bus0.wb_valid = 0; bus0.wb_sel = '0;
    bus0.wb_data = '0; bus0.flush = 0;
  endtask

  task automatic idle1();
    bus1.a_sel = '0; bus1.b_sel = '0;
    bus1.iss_valid = 0; bus1.iss_sel = '0;
    bus1.iss_use_a = 0; bus1.iss_use_b = 0;
    bus1.wb_valid = 0; bus1.wb_sel = '0;
    bus1.wb_data = '0; bus1.flush = 0;
  endtask

  task automatic apply(input vec_t v);
    rst = v.r;
    bus0.a_sel = v.as; bus0.b_sel = v.bs;
    bus0.iss_valid = v.iv; bus0.iss_sel = v.is;
    bus0.iss_use_a = v.ua; bus0.iss_use_b = v.ub;
    bus0.wb_valid = v.wv; bus0.wb_sel = v.ws;
    bus0.wb_data = v.wd; bus0.flush = v.fl;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle0();
    idle1();

    // r  as  bs  iv is  ua ub wv ws  wd       fl ea       eb       es busy
    vecs.push_back(mk(1, 0, 1, 1, 4, 0,0, 1, 3, 16'hAAAA, 0, 16'h0000, 16'h0000, 0, 12'h000));
    vecs.push_back(mk(0, 3, 4, 0, 0, 0,0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 12'h000));
    vecs.push_back(mk(0, 2, 0, 0, 0, 0,0, 1, 2, 16'h1234, 0, 16'h1234, 16'h0000, 0, 12'h000));
    vecs.push_back(mk(0, 2, 2, 0, 0, 0,0, 0, 0, 16'h0000, 0, 16'h1234, 16'h1234, 0, 12'h000));
    vecs.push_back(mk(0, 5, 0, 1, 5, 0,0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 12'h020));
    vecs.push_back(mk(0, 5, 0, 1, 6, 1,0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 12'h020));
    vecs.push_back(mk(0, 5, 0, 1, 6, 1,0, 1, 5, 16'h00FF, 0, 16'h00FF, 16'h0000, 0, 12'h040));
    vecs.push_back(mk(0, 5, 6, 0, 0, 0,0, 0, 0, 16'h0000, 0, 16'h00FF, 16'h0000, 0, 12'h040));
    vecs.push_back(mk(0, 0, 0, 1, 6, 0,0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 12'h040));
    vecs.push_back(mk(0, 6, 6, 1, 6, 0,0, 1, 6, 16'h0606, 0, 16'h0606, 16'h0606, 0, 12'h040));
    vecs.push_back(mk(0, 6, 7, 0, 0, 0,0, 1, 6, 16'h0707, 0, 16'h0707, 16'h0000, 0, 12'h000));
    vecs.push_back(mk(0, 9, 0, 1, 9, 0,0, 1, 9, 16'h8000, 0, 16'h8000, 16'h0000, 0, 12'h200));
    vecs.push_back(mk(0, 9,12, 0, 0, 0,0, 0, 0, 16'h0000, 0, 16'h8000, 16'h0000, 0, 12'h200));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 12'h202));
    vecs.push_back(mk(0, 0, 0, 1, 7, 0,0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 12'h282));
    vecs.push_back(mk(0, 0, 0, 1,11, 0,0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 12'hA82));
    vecs.push_back(mk(0, 1, 3, 1, 3, 0,0, 1, 1, 16'h0042, 1, 16'h0042, 16'h0000, 0, 12'h000));
    vecs.push_back(mk(0, 1, 9, 0, 0, 0,0, 0, 0, 16'h0000, 0, 16'h0042, 16'h8000, 0, 12'h000));
    vecs.push_back(mk(0,13, 6, 1,14, 0,0, 1,13, 16'h5555, 0, 16'h0000, 16'h0707, 0, 12'h000));
    vecs.push_back(mk(0, 0, 0, 1, 4, 0,0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 12'h010));
    vecs.push_back(mk(0, 0, 4, 1, 2, 1,1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 12'h010));
    vecs.push_back(mk(0, 0, 4, 1, 2, 1,1, 1, 4, 16'h4444, 0, 16'h0000, 16'h4444, 0, 12'h004));
    vecs.push_back(mk(0,10, 8, 0, 0, 0,0, 1,10, 16'h1010, 0, 16'h1010, 16'h0000, 0, 12'h004));
    vecs.push_back(mk(0,10,11, 0, 0, 0,0, 0, 0, 16'h0000, 0, 16'h1010, 16'h0000, 0, 12'h004));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d.a_data", i), 32'(bus0.a_data), 32'(vecs[i].ea));
      check($sformatf("v%0d.b_data", i), 32'(bus0.b_data), 32'(vecs[i].eb));
      check($sformatf("v%0d.stall", i), 32'(bus0.stall), 32'(vecs[i].es));
      @(posedge clk);
      #1;
      check($sformatf("v%0d.busy", i), 32'(bus0.busy), 32'(vecs[i].ebusy));
    end

    // Asynchronous reset mid-cycle, then first write after release.
    @(negedge clk);
    idle0();
    bus0.a_sel = 4'd1;
    bus0.b_sel = 4'd10;
    #1;
    check("pre_rst.a_data", 32'(bus0.a_data), 32'h0042);
    check("pre_rst.b_data", 32'(bus0.b_data), 32'h1010);
    #4;
    rst = 1'b1;
    #1;
    check("async_rst.a_data", 32'(bus0.a_data), 32'h0000);
    check("async_rst.b_data", 32'(bus0.b_data), 32'h0000);
    check("async_rst.busy", 32'(bus0.busy), 32'h000);
    bus0.wb_valid = 1; bus0.wb_sel = 4'd1; bus0.wb_data = 16'h1111;
    bus0.iss_valid = 1; bus0.iss_sel = 4'd3;
    bus0.iss_use_a = 1;
    #1;
    check("rst.stall", 32'(bus0.stall), 32'h0);
    @(posedge clk);
    #1;
    bus0.wb_valid = 0;
    bus0.iss_valid = 0;
    #1;
    check("rst_edge.a_data", 32'(bus0.a_data), 32'h0000);
    check("rst_edge.busy", 32'(bus0.busy), 32'h000);
    @(negedge clk);
    rst = 1'b0;
    bus0.wb_valid = 1; bus0.wb_sel = 4'd1; bus0.wb_data = 16'h1111;
    @(posedge clk);
    #1;
    bus0.wb_valid = 0;
    #1;
    check("post_rst.a_data", 32'(bus0.a_data), 32'h1111);

    // ZERO_R0=1 bank: GPR0 hard-wired, never marked busy.
    @(negedge clk);
    idle1();
    bus1.wb_valid = 1; bus1.wb_sel = 4'd0; bus1.wb_data = 16'hFFFF;
    bus1.a_sel = 4'd0;
    #1;
    check("r0.a_data_pre", 32'(bus1.a_data), 32'h0000);
    @(posedge clk);
    #1;
    bus1.wb_valid = 0;
    #1;
    check("r0.a_data_post", 32'(bus1.a_data), 32'h0000);
    @(negedge clk);
    bus1.iss_valid = 1; bus1.iss_sel = 4'd0;
    @(posedge clk);
    #1;
    check("r0.busy", 32'(bus1.busy), 32'h000);
    @(negedge clk);
    bus1.iss_sel = 4'd1;
    @(posedge clk);
    #1;
    bus1.iss_valid = 0;
    check("r0.busy_gpr1", 32'(bus1.busy), 32'h002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
